// File: rtl/cart_rom_server_if.sv
// Memory-controller port used by cart_rom_server: request/ack handshake plus
// a separate one-cycle read-data-valid strobe.
interface cart_rom_server_if #(
  parameter int ADDR_W = 18
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [1:0]        mem_be;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic              mem_valid;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_valid, mem_rdata
  );
endinterface

// File: rtl/cart_rom_server.sv
// Cartridge ROM responder: serves core byte fetches from a 16-bit memory port
// through a one-word line plus a sequential prefetch, and forwards loader writes.
module cart_rom_server #(
  parameter int         ADDR_W      = 18,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              memclk,
  input  logic              cart_sel,
  input  logic [ADDR_W-1:0] cart_addr,
  output logic [7:0]        cart_out,
  input  logic              loading,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  cart_rom_server_if.master mem
);

  localparam int WA_W = ADDR_W - 1;
  typedef logic [WA_W-1:0] waddr_t;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, PF_REQ, PF_WAIT, WR_REQ
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] mclk_sync_q, mclk_sync_d;
  logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
  logic                   mclk_prev_q, mclk_prev_d;
  logic                   load_prev_q, load_prev_d;
  logic                   dem_q, dem_d;
  logic [ADDR_W-1:0]      d_addr_q, d_addr_d;
  logic                   line_v_q, line_v_d;
  waddr_t                 line_addr_q, line_addr_d;
  logic [15:0]            line_data_q, line_data_d;
  logic                   pf_v_q, pf_v_d;
  waddr_t                 pf_addr_q, pf_addr_d;
  logic [15:0]            pf_data_q, pf_data_d;
  logic                   pfq_v_q, pfq_v_d;
  waddr_t                 pfq_addr_q, pfq_addr_d;
  waddr_t                 req_addr_q, req_addr_d;
  logic                   wb_v_q, wb_v_d;
  waddr_t                 wb_addr_q, wb_addr_d;
  logic [1:0]             wb_be_q, wb_be_d;
  logic [15:0]            wb_data_q, wb_data_d;
  logic [7:0]             cart_out_q, cart_out_d;

  logic   mclk_s, sel_s, serve, line_hit, pf_hit;
  waddr_t d_word, dl_word;

  function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : w[7:0];
  endfunction

  assign cart_out = cart_out_q;
  assign dl_wait  = wb_v_q;

  always_comb begin
    state_d     = state_q;
    mclk_sync_d = (mclk_sync_q << 1) | SYNC_STAGES'(memclk);
    sel_sync_d  = (sel_sync_q << 1) | SYNC_STAGES'(cart_sel);
    mclk_s      = mclk_sync_q[SYNC_STAGES-1];
    sel_s       = sel_sync_q[SYNC_STAGES-1];
    mclk_prev_d = mclk_s;
    load_prev_d = loading;
    dem_d       = dem_q;
    d_addr_d    = d_addr_q;
    line_v_d    = line_v_q;
    line_addr_d = line_addr_q;
    line_data_d = line_data_q;
    pf_v_d      = pf_v_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    pfq_v_d     = pfq_v_q;
    pfq_addr_d  = pfq_addr_q;
    req_addr_d  = req_addr_q;
    wb_v_d      = wb_v_q;
    wb_addr_d   = wb_addr_q;
    wb_be_d     = wb_be_q;
    wb_data_d   = wb_data_q;
    cart_out_d  = cart_out_q;

    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_be    = 2'b00;
    mem.mem_addr  = req_addr_q;
    mem.mem_wdata = wb_data_q;

    d_word   = d_addr_q[ADDR_W-1:1];
    dl_word  = dl_addr[ADDR_W-1:1];
    serve    = dem_q && !loading;
    line_hit = line_v_q && (line_addr_q == d_word);
    pf_hit   = pf_v_q && (pf_addr_q == d_word);

    // Line hits are served in any state; only misses and promotions need IDLE.
    if (serve && line_hit) begin
      cart_out_d = sel_byte(line_data_q, d_addr_q[0]);
      dem_d      = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (wb_v_q) begin
          state_d = WR_REQ;
        end else if (serve && !line_hit && !pf_hit) begin
          state_d    = RD_REQ;
          req_addr_d = d_word;
        end else if (serve && pf_hit) begin
          line_v_d    = 1'b1;
          line_addr_d = pf_addr_q;
          line_data_d = pf_data_q;
          pf_v_d      = 1'b0;
          pfq_v_d     = 1'b1;
          pfq_addr_d  = d_word + waddr_t'(1);
          cart_out_d  = sel_byte(pf_data_q, d_addr_q[0]);
          dem_d       = 1'b0;
        end else if (!dem_q && pfq_v_q && !loading) begin
          state_d    = PF_REQ;
          req_addr_d = pfq_addr_q;
          pfq_v_d    = 1'b0;
          pf_v_d     = 1'b0;
          pf_addr_d  = pfq_addr_q;
        end
      end
      RD_REQ: begin
        mem.mem_req = 1'b1;
        mem.mem_be  = 2'b11;
        if (mem.mem_ack) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem.mem_valid) begin
          state_d = IDLE;
          // Data fetched before a download started is stale; drop it.
          if (!loading) begin
            line_v_d    = 1'b1;
            line_addr_d = req_addr_q;
            line_data_d = mem.mem_rdata;
            pfq_v_d     = 1'b1;
            pfq_addr_d  = req_addr_q + waddr_t'(1);
            if (dem_q && (d_word == req_addr_q)) begin
              cart_out_d = sel_byte(mem.mem_rdata, d_addr_q[0]);
              dem_d      = 1'b0;
            end
          end
        end
      end
      PF_REQ: begin
        mem.mem_req = 1'b1;
        mem.mem_be  = 2'b11;
        if (mem.mem_ack) state_d = PF_WAIT;
      end
      PF_WAIT: begin
        if (mem.mem_valid) begin
          state_d = IDLE;
          if (!loading) begin
            pf_v_d    = 1'b1;
            pf_data_d = mem.mem_rdata;
          end
        end
      end
      WR_REQ: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_be   = wb_be_q;
        mem.mem_addr = wb_addr_q;
        if (mem.mem_ack) begin
          state_d = IDLE;
          wb_v_d  = 1'b0;
          // A read that completed while the write sat buffered may hold old data.
          if (line_addr_q == wb_addr_q) line_v_d = 1'b0;
          if (pf_addr_q == wb_addr_q)   pf_v_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (dl_wr && !wb_v_q) begin
      wb_v_d    = 1'b1;
      wb_addr_d = dl_word;
      wb_be_d   = dl_addr[0] ? 2'b10 : 2'b01;
      wb_data_d = {dl_data, dl_data};
      if (line_addr_q == dl_word) line_v_d = 1'b0;
      if (pf_addr_q == dl_word)   pf_v_d   = 1'b0;
    end

    if (mclk_s && !mclk_prev_q && sel_s) begin
      dem_d    = 1'b1;
      d_addr_d = cart_addr;
    end

    if (loading && !load_prev_q) begin
      line_v_d = 1'b0;
      pf_v_d   = 1'b0;
      pfq_v_d  = 1'b0;
    end

    if (loading) begin
      dem_d      = 1'b0;
      cart_out_d = IDLE_BYTE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mclk_sync_q <= '0;
      sel_sync_q  <= '0;
      mclk_prev_q <= 1'b0;
      load_prev_q <= 1'b0;
      dem_q       <= 1'b0;
      d_addr_q    <= '0;
      line_v_q    <= 1'b0;
      line_addr_q <= '0;
      line_data_q <= '0;
      pf_v_q      <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      pfq_v_q     <= 1'b0;
      pfq_addr_q  <= '0;
      req_addr_q  <= '0;
      wb_v_q      <= 1'b0;
      wb_addr_q   <= '0;
      wb_be_q     <= '0;
      wb_data_q   <= '0;
      cart_out_q  <= IDLE_BYTE;
    end else begin
      state_q     <= state_d;
      mclk_sync_q <= mclk_sync_d;
      sel_sync_q  <= sel_sync_d;
      mclk_prev_q <= mclk_prev_d;
      load_prev_q <= load_prev_d;
      dem_q       <= dem_d;
      d_addr_q    <= d_addr_d;
      line_v_q    <= line_v_d;
      line_addr_q <= line_addr_d;
      line_data_q <= line_data_d;
      pf_v_q      <= pf_v_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      pfq_v_q     <= pfq_v_d;
      pfq_addr_q  <= pfq_addr_d;
      req_addr_q  <= req_addr_d;
      wb_v_q      <= wb_v_d;
      wb_addr_q   <= wb_addr_d;
      wb_be_q     <= wb_be_d;
      wb_data_q   <= wb_data_d;
      cart_out_q  <= cart_out_d;
    end
  end

endmodule
